serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built on a single one-bit full-adder cell and a carry flip-flop. It consumes parallel operands plus a carry-in and resolves one bit per clock, LSB first. It returns a parallel sum and a carry-out with a done pulse. It is the sequential stage that drives the one-bit sum/carry logic, trading latency for area against the ripple adder.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is WIDTH ≥ 2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`, input, 1: request; sampled only in IDLE.
- `a`, input, WIDTH: operand A; captured on the accepted `start`.
- `b`, input, WIDTH: operand B; captured on the accepted `start`.
- `cin`, input, 1: carry-in; captured on the accepted `start`.
- `busy`, output, 1: high in RUN and DONE.
- `done`, output, 1: one-cycle pulse; `sum` and `cout` are valid during it.
- `sum`, output, WIDTH: result; held until the next accepted `start`.
- `cout`, output, 1: carry out of the MSB; held with `sum`.
- `ovf`, output, 1: signed overflow; present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE, `start`=1:**
  - Load the A and B shift registers.
  - `carry` ← `cin`, `cnt` ← 0, clear the sum shift register.
  - Go to RUN.
- **IDLE, `start`=0:** stay in IDLE.
- **RUN, each cycle:**
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c = majority(a_sh[0], b_sh[0], carry).
  - Shift s into the sum register at the MSB, shifting right.
  - Shift a_sh and b_sh right, filling with zero.
  - `carry` ← c, `cnt` ← `cnt`+1.
  - When `cnt` = WIDTH−1, go to DONE.
- **DONE:**
  - `done`=1 for this cycle.
  - `cout` holds the final `carry`.
  - Go to IDLE unconditionally.
- `start` in RUN or DONE is ignored; there is no queueing.
- After WIDTH shifts, `sum` equals (a + b + cin) mod 2^WIDTH and `cout` equals bit WIDTH of that sum.
- `cnt` width is $clog2(WIDTH). The terminal compare is exact, so no wrap is used.
- **Reset (`rst_n`=0 on an edge), in any state including mid-RUN:**
  - State → IDLE.
  - `sum`, `cout`, `ovf` (when present), `busy`, `done`, `cnt`, `carry` and the shift registers all → 0.
  - The in-flight operation is discarded.
- Reset has priority over `start` on the same edge.

## Timing
- Let edge k be the edge on which `start` is accepted.
- `busy` rises after edge k.
- RUN spans edges k+1 … k+WIDTH.
- `done`=1 in the cycle following edge k+WIDTH, i.e. latency WIDTH+1 cycles from acceptance.
- `busy` falls after edge k+WIDTH+1.
- Throughput is one operation per WIDTH+2 cycles.
- A `start` held high on the first IDLE cycle after DONE is accepted on that edge.
- `sum` and `cout` are registered, with no combinational path from inputs to outputs.
- `sum` bits change during RUN; they are only guaranteed valid from `done` until the next acceptance.

## Configuration
- Macro: `SERIAL_ADDER_OVF_EN`.
- **Defined:**
  - Adds output `ovf` and a one-bit register `c_msb`.
  - `c_msb` captures the carry into the MSB position, i.e. `carry` at the start of the final RUN cycle.
  - In DONE, `ovf` = `c_msb` ^ `cout`.
  - `ovf` resets to 0 and is held with `sum`.
- **Undefined:** no `ovf` port and no `c_msb` register; all other behaviour is identical.

## Structure
- Shared package `serial_adder_pkg` holds:
  - the state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the default WIDTH constant.
- Sub-module `serial_fa_cell`: purely combinational one-bit full adder with outputs s and c from inputs x, y and ci. It is instantiated once.
- The FSM, counter, shift registers and carry flip-flop live in the top level.

## Test plan
- `a`=8'h05, `b`=8'h03, `cin`=0, `start` pulsed → `done` 9 cycles later, `sum`=8'h08, `cout`=0.
- `a`=8'hFF, `b`=8'h01, `cin`=0 → `sum`=8'h00, `cout`=1, `ovf`=0.
- `a`=8'h7F, `b`=8'h00, `cin`=1 → `sum`=8'h80, `cout`=0, `ovf`=1.
- `start` held high continuously, `a`=8'h10, `b`=8'h20 → acceptances 10 cycles apart.
  - Each result is 8'h30.
  - Operand changes on `a`/`b` during RUN do not affect the result.
- `rst_n` low for one edge at the 4th RUN cycle → next cycle all outputs are 0 and state is IDLE.
  - A following `start` with `a`=8'hAA, `b`=8'h55, `cin`=1 yields `sum`=8'h00, `cout`=1.
- WIDTH=2 instance with `a`=2'b11, `b`=2'b11, `cin`=1 → `done` 3 cycles after acceptance, `sum`=2'b11, `cout`=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int c_DEFAULT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/serial_fa_cell.sv
// ============================================================================
// Module      : serial_fa_cell
// Description : Combinational one-bit full adder used by the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ ci;
  assign c = (x & y) | (x & ci) | (y & ci);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//               Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_c_msb;
`endif

  logic w_s;
  logic w_c;

  serial_fa_cell u_fa (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .c  (w_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_c_msb <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            r_c_msb <= 1'b0;
`endif
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            // r_carry here is the carry into the MSB position
            r_cout  <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
            r_c_msb <= r_carry;
`endif
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_c_msb ^ r_cout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;
  logic       ovf8;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;
  logic       ovf2;

  int n_cmp;
  int n_err;
  int cyc;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf8),
`endif
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf2),
`endif
    .cout  (cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency counts the start cycle as 1, so done arrives at WIDTH+1.
  task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                     input logic ic, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    tick();
    chk({tag, "_busy_rise"}, 32'(busy8), 32'd1);
    start8 = 1'b0;
    lat = 1;
    for (int i = 0; i < 20 && !done8; i++) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_sum"}, 32'(sum8), 32'(es));
    chk({tag, "_cout"}, 32'(cout8), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
`else
    if (eo !== 1'bx) lat = lat;
`endif
    tick();
    chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy8), 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum8), 32'(es));
  endtask

  initial begin
    int t_prev;
    int lat;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    tick(); tick();
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    rst_n = 1'b1;
    tick();

    op8("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_00", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    op8("add_81_80", 8'h81, 8'h80, 1'b0, 8'h01, 1'b1, 1'b1);

    // Continuous start: operands are scrambled mid-RUN and restored in DONE.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    t_prev = 0;
    for (int op = 0; op < 3; op++) begin
      for (int i = 0; i < 30 && !done8; i++) tick();
      chk("held_done_seen", 32'(done8), 32'd1);
      chk("held_sum", 32'(sum8), 32'h30);
      if (op > 0) chk("held_interval", 32'(cyc - t_prev), 32'd10);
      t_prev = cyc;
      a8 = 8'h10; b8 = 8'h20;
      tick(); tick(); tick();
      a8 = 8'hFF; b8 = 8'hEE;
    end
    start8 = 1'b0;
    a8 = 8'h10; b8 = 8'h20;
    for (int i = 0; i < 30 && busy8; i++) tick();
    tick();

    // Reset asserted on the 4th RUN edge aborts the operation.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(cout8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("abort_ovf", 32'(ovf8), 32'd0);
`endif
    op8("post_rst_aa_55", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

    // Minimum width instance.
    a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = 1;
    for (int i = 0; i < 20 && !done2; i++) begin
      tick();
      lat++;
    end
    chk("w2_latency", 32'(lat), 32'd3);
    chk("w2_sum", 32'(sum2), 32'd3);
    chk("w2_cout", 32'(cout2), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("w2_ovf", 32'(ovf2), 32'd0);
`endif
    tick();
    chk("w2_busy_fall", 32'(busy2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
